// File: rtl/dot4_pkg.sv
// Shared parameters and FSM state type for the serial dot-product engine.
// Optional feature macro used by the top: DOT4_CLR_EN (adds a vector-abort input).
package dot4_pkg;

   localparam int DW    = 5;
   localparam int N     = 4;
   localparam int OW    = 12;
   localparam int CNT_W = $clog2(N);

   typedef enum logic [0:0] {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

endpackage

// File: rtl/mul_signed.sv
// Combinational DW x DW signed multiplier with a full-width 2*DW product.
// Shared with the parallel vector multiplier.
module mul_signed
   import dot4_pkg::*;
#(
   parameter int DW = dot4_pkg::DW
) (
   input  logic signed [DW-1:0]   i_a,
   input  logic signed [DW-1:0]   i_b,
   output logic signed [2*DW-1:0] o_p
);

   assign o_p = i_a * i_b;

endmodule

// File: rtl/dot4_serial_mac.sv
// Serial signed dot product of two N-element vectors with one shared MAC.
// Config macro: DOT4_CLR_EN adds i_clr, which aborts the current vector.
module dot4_serial_mac
   import dot4_pkg::*;
#(
   parameter int DW = dot4_pkg::DW,
   parameter int N  = dot4_pkg::N,
   parameter int OW = dot4_pkg::OW
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   input  logic [DW-1:0] i_in_a,
   input  logic [DW-1:0] i_in_b,
   output logic          o_out_valid,
   input  logic          i_out_ready,
   output logic [OW-1:0] o_out_data
`ifdef DOT4_CLR_EN
   ,
   input  logic          i_clr
`endif
);

   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [OW-1:0]       r_acc;
   logic [OW-1:0]       r_out_data;
   logic                r_in_ready;
   logic                r_out_valid;

   logic signed [2*DW-1:0] w_prod;
   logic [OW-1:0]          w_prod_ext;
   logic [OW-1:0]          w_sum;
   logic                   w_accept;

   mul_signed #(
      .DW (DW)
   ) u_mul (
      .i_a (i_in_a),
      .i_b (i_in_b),
      .o_p (w_prod)
   );

   assign w_prod_ext = {{(OW - 2*DW){w_prod[2*DW-1]}}, w_prod};
   assign w_sum      = r_acc + w_prod_ext;
   assign w_accept   = i_in_valid & r_in_ready;

   // Handshake flags are kept as registers alongside the state so outputs are glitch-free.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ACC;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_out_data  <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end
`ifdef DOT4_CLR_EN
      else if (i_clr) begin
         r_state     <= ACC;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end
`endif
      else begin
         case (r_state)
            ACC: begin
               if (w_accept) begin
                  if (r_cnt == CNT_LAST) begin
                     r_out_data  <= w_sum;
                     r_acc       <= '0;
                     r_cnt       <= '0;
                     r_state     <= DONE;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_acc <= w_sum;
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (i_out_ready) begin
                  r_state     <= ACC;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= ACC;
               r_cnt       <= '0;
               r_acc       <= '0;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_dot4_serial_mac.sv
// Directed self-checking bench for dot4_serial_mac; each scenario task checks inline.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_dot4_serial_mac;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_a;
   logic [4:0]  in_b;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_data;
`ifdef DOT4_CLR_EN
   logic        clr;
`endif

   int n_vec;
   int n_bad;

   dot4_serial_mac dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_a      (in_a),
      .i_in_b      (in_b),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data)
`ifdef DOT4_CLR_EN
      ,
      .i_clr       (clr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one pair and wait (bounded) until it is taken at a rising edge.
   task automatic accept_one(input int a, input int b);
      int guard;
      in_a     = 5'(a);
      in_b     = 5'(b);
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drive_vec(input int a[4], input int b[4], input int gap);
      for (int i = 0; i < 4; i++) begin
         accept_one(a[i], b[i]);
         if (i < 3) begin
            for (int g = 0; g < gap; g++) @(negedge clk);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b, want 1", in_ready); end
      n_vec++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b, want 0", out_valid); end
      n_vec++;
      if (out_data !== 12'd0) begin n_bad++; $display("FAIL reset_out_data: got %0d, want 0", $signed(out_data)); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int va[4] = '{1, 3, -1, -5};
      int vb[4] = '{2, -2, 2, -5};
      out_ready = 1'b1;
      drive_vec(va, vb, 0);
      n_vec++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %0b, want 1", out_valid); end
      n_vec++;
      if (out_data !== 12'(19)) begin n_bad++; $display("FAIL basic_data: got %0d, want 19", $signed(out_data)); end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_done_1cycle: got %0b, want 0", out_valid); end
      n_vec++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_back: got %0b, want 1", in_ready); end
   endtask

   task automatic test_back_to_back;
      int va[4] = '{1, 3, 5, 5};
      int vb[4] = '{2, 4, 2, 4};
      out_ready = 1'b1;
      drive_vec(va, vb, 0);
      n_vec++;
      if (out_data !== 12'(44)) begin n_bad++; $display("FAIL b2b_data: got %0d, want 44", $signed(out_data)); end
      n_vec++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_in_done: got %0b, want 0", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_limits;
      int vm[4] = '{-16, -16, -16, -16};
      int vp[4] = '{15, 15, 15, 15};
      out_ready = 1'b1;
      drive_vec(vm, vm, 0);
      n_vec++;
      if (out_data !== 12'(1024)) begin n_bad++; $display("FAIL limit_max: got %0d, want 1024", $signed(out_data)); end
      @(negedge clk);
      drive_vec(vm, vp, 0);
      n_vec++;
      if (out_data !== 12'(-960)) begin n_bad++; $display("FAIL limit_min: got %0d, want -960", $signed(out_data)); end
      @(negedge clk);
   endtask

   task automatic test_stall;
      int va[4] = '{1, 3, -1, -5};
      int vb[4] = '{2, -2, 2, -5};
      int v1[4] = '{2, 2, 2, 2};
      int w1[4] = '{1, 1, 1, 1};
      out_ready = 1'b0;
      drive_vec(va, vb, 1);
      // Offer a pair while the result is pending; it must not be taken.
      in_a     = 5'd7;
      in_b     = 5'd7;
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== 12'(19) || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold[%0d]: valid=%0b data=%0d ready=%0b, want 1/19/0",
                     c, out_valid, $signed(out_data), in_ready);
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 12'(19)) begin
         n_bad++;
         $display("FAIL stall_release: valid=%0b data=%0d, want 0/19", out_valid, $signed(out_data));
      end
      drive_vec(v1, w1, 0);
      n_vec++;
      if (out_data !== 12'(8)) begin n_bad++; $display("FAIL stall_no_extra_accept: got %0d, want 8", $signed(out_data)); end
      @(negedge clk);
   endtask

   task automatic test_rst_abort;
      int v1[4] = '{1, 1, 1, 1};
      int vb[4] = '{2, -2, 2, -5};
      out_ready = 1'b1;
      accept_one(7, 7);
      accept_one(7, 7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive_vec(v1, v1, 0);
      n_vec++;
      if (out_data !== 12'(4)) begin n_bad++; $display("FAIL rst_abort_data: got %0d, want 4", $signed(out_data)); end
      @(negedge clk);
      // Reset while a result is pending discards it.
      out_ready = 1'b0;
      drive_vec(vb, vb, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 12'd0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_in_done: valid=%0b data=%0d ready=%0b, want 0/0/1",
                  out_valid, $signed(out_data), in_ready);
      end
      out_ready = 1'b1;
   endtask

`ifdef DOT4_CLR_EN
   task automatic test_clr;
      int va[4] = '{2, 0, 0, 0};
      int vb[4] = '{3, 0, 0, 0};
      out_ready = 1'b1;
      accept_one(5, 5);
      accept_one(5, 5);
      accept_one(5, 5);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      drive_vec(va, vb, 0);
      n_vec++;
      if (out_data !== 12'(6)) begin n_bad++; $display("FAIL clr_abort_data: got %0d, want 6", $signed(out_data)); end
      @(negedge clk);
      out_ready = 1'b0;
      drive_vec(va, vb, 0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL clr_in_done: valid=%0b ready=%0b, want 0/1", out_valid, in_ready);
      end
      out_ready = 1'b1;
   endtask
`endif

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 5'd0;
      in_b      = 5'd0;
      out_ready = 1'b0;
`ifdef DOT4_CLR_EN
      clr       = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_limits();
      test_stall();
      test_rst_abort();
`ifdef DOT4_CLR_EN
      test_clr();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
